// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670-style sensor model: FSM states,
// pattern mode encodings and the colour-bar palette.
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VS,
    ST_VBP,
    ST_LINE,
    ST_HBLK,
    ST_VFP
  } state_e;

  // Any other mode value (3) falls back to the solid colour.
  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_RAMP  = 2'd2;

  localparam logic [15:0] BAR_0 = 16'hFFFF;
  localparam logic [15:0] BAR_1 = 16'hFFE0;
  localparam logic [15:0] BAR_2 = 16'h07FF;
  localparam logic [15:0] BAR_3 = 16'h07E0;
  localparam logic [15:0] BAR_4 = 16'hF81F;
  localparam logic [15:0] BAR_5 = 16'hF800;
  localparam logic [15:0] BAR_6 = 16'h001F;
  localparam logic [15:0] BAR_7 = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_0;
      3'd1:    c = BAR_1;
      3'd2:    c = BAR_2;
      3'd3:    c = BAR_3;
      3'd4:    c = BAR_4;
      3'd5:    c = BAR_5;
      3'd6:    c = BAR_6;
      default: c = BAR_7;
    endcase
    return c;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ov7670_pattern.sv
// Test-pattern byte generator: solid colour, eight colour bars, or a free
// running byte ramp that advances once per emitted line byte.
import ov7670_pkg::*;

module ov7670_pattern #(
  parameter int H_ACTIVE = 160,
  parameter int XW       = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          advance_i,
  input  logic [XW-1:0] x_i,
  input  logic          phase_i,
  input  logic [1:0]    mode_i,
  input  logic [15:0]   color_i,
  output logic [7:0]    byte_o
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [7:0]  ramp_q, ramp_d;
  logic [2:0]  bar;
  logic [15:0] pix;

  // Bar index by threshold compare, avoiding a divider for non-power-of-2 widths.
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(x_i) >= k * BAR_W) bar = 3'(k);
    end
  end

  always_comb begin
    ramp_d = ramp_q;
    if (clear_i)        ramp_d = 8'd0;
    else if (advance_i) ramp_d = ramp_q + 8'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ramp_q <= 8'd0;
    else       ramp_q <= ramp_d;
  end

  always_comb begin
    pix    = color_i;
    byte_o = 8'd0;
    case (mode_i)
      MODE_BARS:  pix = bar_color(bar);
      MODE_SOLID: pix = color_i;
      default:    pix = color_i;
    endcase
    byte_o = phase_i ? pix[7:0] : pix[15:8];
    if (mode_i == MODE_RAMP) byte_o = ramp_q;
  end

endmodule

// File: rtl/ov7670_sensor_model.sv
// OV7670-style frame timing generator: VSYNC/HREF/D sequencing with one byte
// per clock. Outputs are registered copies of the state decode, one cycle late.
import ov7670_pkg::*;

module ov7670_sensor_model #(
  parameter int H_ACTIVE  = 160,
  parameter int V_ACTIVE  = 120,
  parameter int H_BLANK   = 144,
  parameter int VSYNC_CYC = 1568,
  parameter int VBP_CYC   = 5488,
  parameter int VFP_CYC   = 3136
) (
  input  logic        reloj,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] color,
  output logic        VSYNC,
  output logic        HREF,
  output logic [7:0]  D,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int MAX_N = max_int(max_int(max_int(VSYNC_CYC, VBP_CYC),
                                         max_int(VFP_CYC, H_BLANK)), 2 * H_ACTIVE);
  localparam int CW = $clog2(MAX_N);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [YW-1:0]   y_q, y_d;
  logic [1:0]      mode_q, mode_d;
  logic [15:0]     color_q, color_d;
  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic [7:0]      d_q, d_d;
  logic            frame_done_q, frame_done_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            last;
  logic            entering_vs;
  logic [7:0]      pat_byte;

  always_comb begin
    last = 1'b0;
    case (state_q)
      ST_VS:   last = (cnt_q == CW'(VSYNC_CYC - 1));
      ST_VBP:  last = (cnt_q == CW'(VBP_CYC - 1));
      ST_LINE: last = (cnt_q == CW'(2 * H_ACTIVE - 1));
      ST_HBLK: last = (cnt_q == CW'(H_BLANK - 1));
      ST_VFP:  last = (cnt_q == CW'(VFP_CYC - 1));
      default: last = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = last ? '0 : cnt_q + CW'(1);
    y_d     = y_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) state_d = ST_VS;
      end
      ST_VS:   if (last) state_d = ST_VBP;
      ST_VBP: begin
        if (last) begin
          state_d = ST_LINE;
          y_d     = '0;
        end
      end
      ST_LINE: if (last) state_d = ST_HBLK;
      ST_HBLK: begin
        if (last) begin
          if (y_q == YW'(V_ACTIVE - 1)) begin
            state_d = ST_VFP;
          end else begin
            state_d = ST_LINE;
            y_d     = y_q + YW'(1);
          end
        end
      end
      // enable is only looked at here and in IDLE, so a frame never truncates.
      ST_VFP:  if (last) state_d = enable ? ST_VS : ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    entering_vs = (state_d == ST_VS) && (state_q != ST_VS);
    mode_d      = entering_vs ? mode  : mode_q;
    color_d     = entering_vs ? color : color_q;

    vsync_d      = (state_q == ST_VS);
    href_d       = (state_q == ST_LINE);
    d_d          = href_d ? pat_byte : 8'd0;
    frame_done_d = (state_q == ST_VFP) && last;
    frame_cnt_d  = frame_cnt_q + {15'd0, frame_done_d};
  end

  ov7670_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW)
  ) u_pattern (
    .clk_i     (reloj),
    .rst_i     (rst),
    .clear_i   (entering_vs),
    .advance_i (state_q == ST_LINE),
    .x_i       (cnt_q[XW:1]),
    .phase_i   (cnt_q[0]),
    .mode_i    (mode_q),
    .color_i   (color_q),
    .byte_o    (pat_byte)
  );

  always_ff @(posedge reloj or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      y_q          <= '0;
      mode_q       <= MODE_SOLID;
      color_q      <= 16'd0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      d_q          <= 8'd0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      y_q          <= y_d;
      mode_q       <= mode_d;
      color_q      <= color_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      d_q          <= d_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign VSYNC      = vsync_q;
  assign HREF       = href_q;
  assign D          = d_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_ov7670_sensor_model.sv
// Directed bench for ov7670_sensor_model using a shrunken frame geometry so
// several complete frames fit in a short run.
module tb_ov7670_sensor_model;

  localparam int H   = 16;
  localparam int V   = 4;
  localparam int HB  = 6;
  localparam int VSC = 5;
  localparam int VBP = 7;
  localparam int VFP = 9;
  localparam int LINE_CYC   = 2 * H + HB;                 // 38
  localparam int FRAME_CYC  = VSC + VBP + V * LINE_CYC + VFP; // 173
  localparam int HREF_TOTAL = 2 * H * V;                  // 128
  localparam logic [15:0] BAR_TBL [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic        reloj = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] color = 16'd0;
  logic        VSYNC, HREF, frame_done;
  logic [7:0]  D;
  logic [15:0] frame_cnt;

  int pass_cnt = 0;
  int check_cnt = 0;

  logic       vs_a [512];
  logic       hr_a [512];
  logic       fd_a [512];
  logic [7:0] d_a  [512];
  int         n_rec;
  logic       cap_done;

  ov7670_sensor_model #(
    .H_ACTIVE (H), .V_ACTIVE (V), .H_BLANK (HB),
    .VSYNC_CYC (VSC), .VBP_CYC (VBP), .VFP_CYC (VFP)
  ) dut (
    .reloj (reloj), .rst (rst), .enable (enable), .mode (mode), .color (color),
    .VSYNC (VSYNC), .HREF (HREF), .D (D),
    .frame_done (frame_done), .frame_cnt (frame_cnt)
  );

  always #5 reloj = ~reloj;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Record one frame sample per cycle until frame_done; optionally change inputs at index chg_at.
  task automatic capture(input int chg_at, input logic en_after, input logic [1:0] mode_after);
    n_rec = 0;
    cap_done = 1'b0;
    for (int i = 0; i < 400 && !cap_done; i++) begin
      @(negedge reloj);
      vs_a[i] = VSYNC; hr_a[i] = HREF; d_a[i] = D; fd_a[i] = frame_done;
      n_rec = i + 1;
      if (frame_done) cap_done = 1'b1;
      if (i == chg_at) begin
        enable = en_after;
        mode = mode_after;
      end
    end
  endtask

  function automatic int first_vs();
    for (int i = 0; i < n_rec; i++) if (vs_a[i]) return i;
    return -1;
  endfunction

  function automatic int first_hr();
    for (int i = 0; i < n_rec; i++) if (hr_a[i]) return i;
    return -1;
  endfunction

  function automatic int fd_idx();
    for (int i = 0; i < n_rec; i++) if (fd_a[i]) return i;
    return -1;
  endfunction

  function automatic int vs_count();
    int c = 0;
    for (int i = 0; i < n_rec; i++) if (vs_a[i]) c++;
    return c;
  endfunction

  function automatic int hr_count();
    int c = 0;
    for (int i = 0; i < n_rec; i++) if (hr_a[i]) c++;
    return c;
  endfunction

  function automatic int fd_count();
    int c = 0;
    for (int i = 0; i < n_rec; i++) if (fd_a[i]) c++;
    return c;
  endfunction

  function automatic int line_count();
    int c = 0;
    for (int i = 0; i < n_rec; i++) if (hr_a[i] && (i == 0 || !hr_a[i-1])) c++;
    return c;
  endfunction

  function automatic int bad_idle_bytes();
    int c = 0;
    for (int i = 0; i < n_rec; i++) begin
      if (!hr_a[i] && d_a[i] !== 8'd0) c++;
      if (hr_a[i] && vs_a[i]) c++;
    end
    return c;
  endfunction

  function automatic int ramp_errs();
    int c = 0;
    int k = 0;
    for (int i = 0; i < n_rec; i++) begin
      if (hr_a[i]) begin
        if (d_a[i] !== 8'(k)) c++;
        k++;
      end
    end
    return c;
  endfunction

  task automatic test_reset();
    @(negedge reloj);
    check_cnt++;
    if ({VSYNC, HREF, D, frame_done, frame_cnt} !== 27'd0)
      $display("FAIL reset_outputs: got %h want 0", {VSYNC, HREF, D, frame_done, frame_cnt});
    else pass_cnt++;
    rst = 1'b0;
    repeat (5) @(negedge reloj);
    check_cnt++;
    if ({VSYNC, HREF, D, frame_done, frame_cnt} !== 27'd0)
      $display("FAIL idle_no_enable: got %h want 0", {VSYNC, HREF, D, frame_done, frame_cnt});
    else pass_cnt++;
    $display("test_reset: done");
  endtask

  task automatic test_solid();
    int errs = 0;
    int k = 0;
    @(negedge reloj);
    mode = 2'd0; color = 16'hABCD; enable = 1'b1;
    capture(0, 1'b0, 2'd0);
    check_cnt++;
    if (cap_done !== 1'b1) $display("FAIL solid_frame_done_seen: got %0b want 1", cap_done);
    else pass_cnt++;
    check_cnt++;
    if (first_vs() !== 1) $display("FAIL start_latency: got %0d want 1", first_vs());
    else pass_cnt++;
    check_cnt++;
    if (vs_count() !== VSC) $display("FAIL vsync_len: got %0d want %0d", vs_count(), VSC);
    else pass_cnt++;
    check_cnt++;
    if (first_hr() - (first_vs() + vs_count()) !== VBP)
      $display("FAIL vbp_len: got %0d want %0d", first_hr() - (first_vs() + vs_count()), VBP);
    else pass_cnt++;
    check_cnt++;
    if (hr_count() !== HREF_TOTAL) $display("FAIL solid_href_total: got %0d want %0d", hr_count(), HREF_TOTAL);
    else pass_cnt++;
    for (int i = 0; i < n_rec; i++) begin
      if (hr_a[i]) begin
        if (d_a[i] !== ((k % 2 == 0) ? 8'hAB : 8'hCD)) errs++;
        k++;
      end
    end
    check_cnt++;
    if (errs !== 0) $display("FAIL solid_bytes: got %0d bad bytes want 0", errs);
    else pass_cnt++;
    check_cnt++;
    if (bad_idle_bytes() !== 0) $display("FAIL solid_idle_d_or_overlap: got %0d want 0", bad_idle_bytes());
    else pass_cnt++;
    check_cnt++;
    if (fd_count() !== 1) $display("FAIL solid_done_pulses: got %0d want 1", fd_count());
    else pass_cnt++;
    check_cnt++;
    if (fd_idx() !== FRAME_CYC) $display("FAIL frame_length: got %0d want %0d", fd_idx(), FRAME_CYC);
    else pass_cnt++;
    check_cnt++;
    if (frame_cnt !== 16'd1) $display("FAIL solid_frame_cnt: got %0d want 1", frame_cnt);
    else pass_cnt++;
    repeat (4) @(negedge reloj);
    check_cnt++;
    if ({VSYNC, HREF, D, frame_done} !== 11'd0)
      $display("FAIL solid_back_to_idle: got %h want 0", {VSYNC, HREF, D, frame_done});
    else pass_cnt++;
    $display("test_solid: frame_cnt=%0d href=%0d", frame_cnt, hr_count());
  endtask

  task automatic test_bars();
    int errs = 0;
    int k = 0;
    int j;
    logic [15:0] pix;
    logic [7:0] exp_b;
    @(negedge reloj);
    mode = 2'd1; enable = 1'b1;
    // Mode switches to ramp right after VS entry: this frame must stay bars.
    capture(0, 1'b1, 2'd2);
    for (int i = 0; i < n_rec; i++) begin
      if (hr_a[i]) begin
        j = k % (2 * H);
        pix = BAR_TBL[(j / 2) / (H / 8)];
        exp_b = (j % 2 == 1) ? pix[7:0] : pix[15:8];
        if (d_a[i] !== exp_b) errs++;
        k++;
      end
    end
    check_cnt++;
    if (errs !== 0) $display("FAIL bars_bytes: got %0d bad bytes want 0", errs);
    else pass_cnt++;
    check_cnt++;
    if (line_count() !== V) $display("FAIL bars_lines: got %0d want %0d", line_count(), V);
    else pass_cnt++;
    check_cnt++;
    if (fd_idx() !== FRAME_CYC) $display("FAIL bars_frame_length: got %0d want %0d", fd_idx(), FRAME_CYC);
    else pass_cnt++;
    check_cnt++;
    if (frame_cnt !== 16'd2) $display("FAIL bars_frame_cnt: got %0d want 2", frame_cnt);
    else pass_cnt++;
    $display("test_bars: bad=%0d frame_cnt=%0d", errs, frame_cnt);
  endtask

  task automatic test_back_to_back_ramp();
    capture(0, 1'b0, 2'd2);
    check_cnt++;
    if (first_vs() !== 0) $display("FAIL back_to_back_vsync: got %0d want 0", first_vs());
    else pass_cnt++;
    check_cnt++;
    if (vs_count() !== VSC) $display("FAIL ramp_vsync_len: got %0d want %0d", vs_count(), VSC);
    else pass_cnt++;
    check_cnt++;
    if (ramp_errs() !== 0) $display("FAIL ramp_bytes: got %0d bad bytes want 0", ramp_errs());
    else pass_cnt++;
    check_cnt++;
    if (d_a[first_hr() + LINE_CYC] !== 8'h20)
      $display("FAIL ramp_line2_start: got %h want 20", d_a[first_hr() + LINE_CYC]);
    else pass_cnt++;
    check_cnt++;
    if (fd_idx() !== FRAME_CYC - 1) $display("FAIL ramp_frame_length: got %0d want %0d", fd_idx(), FRAME_CYC - 1);
    else pass_cnt++;
    check_cnt++;
    if (frame_cnt !== 16'd3) $display("FAIL ramp_frame_cnt: got %0d want 3", frame_cnt);
    else pass_cnt++;
    $display("test_back_to_back_ramp: frame_cnt=%0d", frame_cnt);
  endtask

  task automatic test_enable_drop();
    int bad = 0;
    @(negedge reloj);
    mode = 2'd0; color = 16'h1234; enable = 1'b1;
    // Index 94 sits in the middle of the third line (line 2).
    capture(94, 1'b0, 2'd0);
    check_cnt++;
    if (hr_a[94] !== 1'b1) $display("FAIL drop_mid_line: got %0b want 1", hr_a[94]);
    else pass_cnt++;
    check_cnt++;
    if (line_count() !== V) $display("FAIL drop_lines: got %0d want %0d", line_count(), V);
    else pass_cnt++;
    check_cnt++;
    if (hr_count() !== HREF_TOTAL) $display("FAIL drop_href_total: got %0d want %0d", hr_count(), HREF_TOTAL);
    else pass_cnt++;
    check_cnt++;
    if (frame_cnt !== 16'd4) $display("FAIL drop_frame_cnt: got %0d want 4", frame_cnt);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      @(negedge reloj);
      if ({VSYNC, HREF, D, frame_done} !== 11'd0) bad++;
    end
    check_cnt++;
    if (bad !== 0) $display("FAIL drop_idle_after: got %0d busy cycles want 0", bad);
    else pass_cnt++;
    $display("test_enable_drop: frame_cnt=%0d", frame_cnt);
  endtask

  task automatic test_async_reset();
    @(negedge reloj);
    mode = 2'd2; enable = 1'b1;
    for (int i = 0; i < 100 && !HREF; i++) @(negedge reloj);
    check_cnt++;
    if (HREF !== 1'b1) $display("FAIL rst_reach_line: got %0b want 1", HREF);
    else pass_cnt++;
    repeat (3) @(negedge reloj);
    #2 rst = 1'b1;
    #1;
    check_cnt++;
    if ({VSYNC, HREF, D, frame_cnt} !== 26'd0)
      $display("FAIL async_reset_outputs: got %h want 0", {VSYNC, HREF, D, frame_cnt});
    else pass_cnt++;
    @(negedge reloj);
    rst = 1'b0;
    capture(0, 1'b0, 2'd2);
    check_cnt++;
    if (first_vs() !== 1) $display("FAIL rst_restart_latency: got %0d want 1", first_vs());
    else pass_cnt++;
    check_cnt++;
    if (ramp_errs() !== 0) $display("FAIL rst_ramp_bytes: got %0d bad bytes want 0", ramp_errs());
    else pass_cnt++;
    check_cnt++;
    if (fd_idx() !== FRAME_CYC) $display("FAIL rst_frame_length: got %0d want %0d", fd_idx(), FRAME_CYC);
    else pass_cnt++;
    check_cnt++;
    if (frame_cnt !== 16'd1) $display("FAIL rst_frame_cnt: got %0d want 1", frame_cnt);
    else pass_cnt++;
    $display("test_async_reset: frame_cnt=%0d", frame_cnt);
  endtask

  initial begin
    test_reset();
    test_solid();
    test_bars();
    test_back_to_back_ramp();
    test_enable_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
